scan_mux_n_to_1: RTL and testbench
==================================

// Module: scan_mux_n_to_1
// PURPOSE
//   Parametrised CH-to-1 multiplexer, W bits per channel, with a registered output and an active-low enable.
//   Two modes: manual select on S, or auto-scan, which steps through every channel and holds each one for
//   DWELL+1 clocks. Drives a serialised monitor/display path. Reports the presented channel, a valid flag
//   and a wrap pulse.
// PARAMETERS
//   CH       8   number of input channels, >=1
//   W        1   data width per channel, >=1
//   DWELL_W  8   width of DWELL port
//   SEL_W    localparam = (CH>1) ? $clog2(CH) : 1
// PORTS
//   CLK      in   1         clock, all state on rising edge
//   RST_BAR  in   1         asynchronous reset, active-low
//   EN_BAR   in   1         enable, active-low; 1 = disabled
//   MODE     in   1         0 = manual (S), 1 = auto-scan
//   S        in   SEL_W     manual channel select
//   DWELL    in   DWELL_W   auto-scan hold = DWELL+1 clocks per channel
//   IN       in   CH*W      packed inputs; channel k = IN[k*W +: W]
//   OUTPUT   out  W         registered selected data
//   CH_SEL   out  SEL_W     channel currently on OUTPUT (aligned with OUTPUT)
//   VALID    out  1         OUTPUT holds legal channel data
//   WRAP     out  1         1-clock pulse: scan returned from CH-1 to 0
// BEHAVIOUR
//   Reset (RST_BAR=0, immediate, any time)
//     - OUTPUT=0, CH_SEL=0, VALID=0, WRAP=0.
//     - Dwell counter cnt=0; state IDLE.
//   States: IDLE, MANUAL, SCAN. The state is chosen at every edge from EN_BAR/MODE:
//     EN_BAR=1 -> IDLE; EN_BAR=0 & MODE=0 -> MANUAL; EN_BAR=0 & MODE=1 -> SCAN.
//   IDLE edge
//     - OUTPUT<=0, VALID<=0, WRAP<=0, cnt<=0.
//     - CH_SEL holds its value.
//   MANUAL edge (1-clock latency)
//     - If S<CH: OUTPUT<=IN[S], CH_SEL<=S, VALID<=1.
//     - If S>=CH (CH not a power of 2): OUTPUT<=0, VALID<=0, CH_SEL holds.
//     - Always: WRAP<=0, cnt<=0.
//   SCAN edge
//     - First SCAN edge after IDLE/MANUAL/reset:
//         CH_SEL<=0, OUTPUT<=IN[0], VALID<=1, cnt<=0, WRAP<=0.
//     - Later edge with cnt>=DWELL (>= so that lowering DWELL mid-dwell advances at once):
//         nxt = (CH_SEL==CH-1) ? 0 : CH_SEL+1;
//         CH_SEL<=nxt, OUTPUT<=IN[nxt], cnt<=0.
//         WRAP<=1 only when CH_SEL==CH-1, else 0.
//     - Otherwise: OUTPUT<=IN[CH_SEL] (tracks live input), cnt<=cnt+1, WRAP<=0.
//   Corner cases
//     - CH=1: CH_SEL stays 0; WRAP pulses at every dwell expiry.
//     - DWELL=0: channel advances every clock.
//     - MODE or EN_BAR change mid-scan: takes effect at the next edge.
//     - Re-entering SCAN always restarts at channel 0.
//     - Reset mid-dwell clears cnt; no partial dwell survives.
//   No combinational path from any input to any output.
// TESTING
//   1 RST_BAR=0 with IN/S toggling -> all outputs 0 throughout; release -> still 0 until first enabled edge.
//   2 CH=8 W=1, IN=8'b1010_1011, EN_BAR=1, S swept 0..7 -> OUTPUT=0, VALID=0 every cycle.
//   3 Same IN, EN_BAR=0, MODE=0, S=0..7 one per clock -> OUTPUT one clock later = 1,1,0,1,0,1,0,1;
//     CH_SEL=S delayed one clock; VALID=1.
//   4 EN_BAR=0, MODE=1, DWELL=2 -> CH_SEL = 0,0,0,1,1,1,...,7,7,7 over SCAN edges 1-24;
//     edge 25 -> CH_SEL=0, WRAP=1 for that clock only.
//   5 CH=5 W=4, MODE=0: S=6 -> OUTPUT=0, VALID=0; S=4 -> OUTPUT=IN[19:16], VALID=1.
//     Then MODE=1, DWELL=5 and at cnt=3 set DWELL=1 -> advance on the next edge.
//   6 During scan at CH_SEL=3:
//     - EN_BAR=1 one clock -> OUTPUT=0, VALID=0; EN_BAR=0 -> restart at CH_SEL=0.
//     - RST_BAR pulse mid-dwell -> outputs clear immediately, without waiting for a clock.

Source files
------------

// File: rtl/scan_mux_n_to_1.sv
// CH-to-1 registered multiplexer with manual select or auto-scan. Each channel is held
// for DWELL+1 clocks during a scan, and a one-clock wrap pulse marks the return to channel 0.
module scan_mux_n_to_1 #(
    parameter int CH      = 8,
    parameter int W       = 1,
    parameter int DWELL_W = 8,
    localparam int SEL_W  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_bar_i,
    input  logic                 en_bar_i,
    input  logic                 mode_i,
    input  logic [SEL_W-1:0]     s_i,
    input  logic [DWELL_W-1:0]   dwell_i,
    input  logic [CH*W-1:0]      in_i,
    output logic [W-1:0]         output_o,
    output logic [SEL_W-1:0]     ch_sel_o,
    output logic                 valid_o,
    output logic                 wrap_o
);

    // state  | meaning
    // IDLE   | disabled: output and valid cleared, channel select held
    // MANUAL | channel taken from s_i each clock
    // SCAN   | channels stepped 0..CH-1, DWELL+1 clocks each
    typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_e;

    localparam logic [SEL_W:0]   CH_NUM  = (SEL_W + 1)'(CH);
    localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(CH - 1);

    state_e               state_q, state_d;
    logic [W-1:0]         data_q, data_d;
    logic [SEL_W-1:0]     ch_sel_q, ch_sel_d;
    logic                 valid_q, valid_d;
    logic                 wrap_q, wrap_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]     idx;
    logic                 idx_ok;

    always_ff @(posedge clk_i or negedge rst_bar_i) begin
        if (!rst_bar_i) begin
            state_q  <= IDLE;
            data_q   <= '0;
            ch_sel_q <= '0;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            ch_sel_q <= ch_sel_d;
            valid_q  <= valid_d;
            wrap_q   <= wrap_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = IDLE;
        if (!en_bar_i) state_d = mode_i ? SCAN : MANUAL;
        data_d   = '0;
        ch_sel_d = ch_sel_q;
        wrap_d   = 1'b0;
        cnt_d    = '0;
        idx      = '0;
        idx_ok   = 1'b0;
        case (state_d)
            MANUAL: begin
                if ({1'b0, s_i} < CH_NUM) begin
                    idx      = s_i;
                    idx_ok   = 1'b1;
                    ch_sel_d = s_i;
                end
            end
            SCAN: begin
                idx_ok = 1'b1;
                // >= lets a lowered DWELL end the current dwell immediately
                if (state_q != SCAN) begin
                    idx = '0;
                end else if (cnt_q >= dwell_i) begin
                    idx    = (ch_sel_q == CH_LAST) ? '0 : ch_sel_q + 1'b1;
                    wrap_d = (ch_sel_q == CH_LAST);
                end else begin
                    idx   = ch_sel_q;
                    cnt_d = cnt_q + 1'b1;
                end
                ch_sel_d = idx;
            end
            default: ;
        endcase
        valid_d = idx_ok;
        for (int k = 0; k < CH; k++) begin
            if (idx_ok && idx == SEL_W'(k)) data_d = in_i[k*W +: W];
        end
    end

    assign output_o = data_q;
    assign ch_sel_o = ch_sel_q;
    assign valid_o  = valid_q;
    assign wrap_o   = wrap_q;

endmodule

// File: tb/tb_scan_mux_n_to_1.sv
// Bench for scan_mux_n_to_1: an 8x1 instance and a 5x4 instance, checked through a
// scoreboard queue of expected outputs per clock, plus direct checks of the async reset.
module tb_scan_mux_n_to_1;

    typedef struct {
        int         dut;
        logic [3:0] out;
        logic [2:0] ch;
        logic       valid;
        logic       wrap;
        string      name;
    } exp_t;

    typedef struct {
        logic       en_bar;
        logic       mode;
        logic [2:0] s;
        logic       out;
        logic [2:0] ch;
        logic       valid;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    logic        en8, mode8, valid8, wrap8;
    logic [2:0]  s8, ch8;
    logic [7:0]  dwell8, in8;
    logic [0:0]  out8;

    logic        en5, mode5, valid5, wrap5;
    logic [2:0]  s5, ch5;
    logic [7:0]  dwell5;
    logic [19:0] in5;
    logic [3:0]  out5;

    exp_t sb[$];
    vec_t vecs[16];
    logic exp3[8];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    scan_mux_n_to_1 #(.CH(8), .W(1), .DWELL_W(8)) u8 (
        .clk_i(clk), .rst_bar_i(rst_n), .en_bar_i(en8), .mode_i(mode8), .s_i(s8),
        .dwell_i(dwell8), .in_i(in8), .output_o(out8), .ch_sel_o(ch8),
        .valid_o(valid8), .wrap_o(wrap8)
    );

    scan_mux_n_to_1 #(.CH(5), .W(4), .DWELL_W(8)) u5 (
        .clk_i(clk), .rst_bar_i(rst_n), .en_bar_i(en5), .mode_i(mode5), .s_i(s5),
        .dwell_i(dwell5), .in_i(in5), .output_o(out5), .ch_sel_o(ch5),
        .valid_o(valid5), .wrap_o(wrap5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int dut, input logic [3:0] out, input logic [2:0] ch,
                        input logic v, input logic w, input string name);
        exp_t e;
        e.dut = dut; e.out = out; e.ch = ch; e.valid = v; e.wrap = w; e.name = name;
        sb.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.dut == 8) begin
            chk({e.name, ".out"},   32'(out8),   32'(e.out));
            chk({e.name, ".ch"},    32'(ch8),    32'(e.ch));
            chk({e.name, ".valid"}, 32'(valid8), 32'(e.valid));
            chk({e.name, ".wrap"},  32'(wrap8),  32'(e.wrap));
        end else begin
            chk({e.name, ".out"},   32'(out5),   32'(e.out));
            chk({e.name, ".ch"},    32'(ch5),    32'(e.ch));
            chk({e.name, ".valid"}, 32'(valid5), 32'(e.valid));
            chk({e.name, ".wrap"},  32'(wrap5),  32'(e.wrap));
        end
    endtask

    task automatic step8(input logic en_b, input logic mode, input logic [2:0] s,
                         input logic [7:0] dwell, input logic eo, input logic [2:0] ech,
                         input logic ev, input logic ew, input string name);
        en8 = en_b; mode8 = mode; s8 = s; dwell8 = dwell;
        push(8, {3'b000, eo}, ech, ev, ew, name);
        cycle();
    endtask

    task automatic step5(input logic en_b, input logic mode, input logic [2:0] s,
                         input logic [7:0] dwell, input int ech,
                         input logic ev, input logic ew, input string name);
        logic [3:0] eo;
        en5 = en_b; mode5 = mode; s5 = s; dwell5 = dwell;
        eo = ev ? in5[ech*4 +: 4] : 4'h0;
        push(5, eo, 3'(ech), ev, ew, name);
        cycle();
    endtask

    initial begin
        int ch;
        int seq5[8];

        exp3 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            vecs[i]     = '{en_bar: 1'b1, mode: 1'b0, s: 3'(i), out: 1'b0, ch: 3'd0, valid: 1'b0};
            vecs[8 + i] = '{en_bar: 1'b0, mode: 1'b0, s: 3'(i), out: exp3[i], ch: 3'(i), valid: 1'b1};
        end
        seq5 = '{2, 2, 3, 3, 4, 4, 0, 0};

        rst_n = 1'b0;
        en8 = 1'b0; mode8 = 1'b0; s8 = '0; dwell8 = '0; in8 = '0;
        en5 = 1'b1; mode5 = 1'b0; s5 = '0; dwell5 = '0; in5 = 20'hD963B;

        // held in reset with enabled inputs toggling: outputs stay cleared
        for (int i = 0; i < 4; i++) begin
            in8 = 8'($urandom);
            step8(1'b0, 1'(i & 1), 3'(i * 3), 8'd0, 1'b0, 3'd0, 1'b0, 1'b0, $sformatf("rst%0d", i));
        end
        in8 = 8'b1010_1011;
        rst_n = 1'b1;
        step8(1'b1, 1'b0, 3'd5, 8'd0, 1'b0, 3'd0, 1'b0, 1'b0, "post_rst");

        for (int i = 0; i < 16; i++) begin
            step8(vecs[i].en_bar, vecs[i].mode, vecs[i].s, 8'd0, vecs[i].out, vecs[i].ch,
                  vecs[i].valid, 1'b0, $sformatf("vec%0d", i));
        end

        // auto-scan, DWELL=2: three clocks per channel, wrap on edge 25
        for (int e = 1; e <= 34; e++) begin
            ch = ((e - 1) / 3) % 8;
            step8(1'b0, 1'b1, 3'd0, 8'd2, exp3[ch], 3'(ch), 1'b1,
                  (e > 1) && ((e - 1) % 24 == 0), $sformatf("scan%0d", e));
        end

        step8(1'b1, 1'b1, 3'd0, 8'd2, 1'b0, 3'd3, 1'b0, 1'b0, "dis_mid");
        step8(1'b0, 1'b1, 3'd0, 8'd2, 1'b1, 3'd0, 1'b1, 1'b0, "restart0");
        step8(1'b0, 1'b1, 3'd0, 8'd2, 1'b1, 3'd0, 1'b1, 1'b0, "restart1");
        step8(1'b0, 1'b1, 3'd0, 8'd2, 1'b1, 3'd0, 1'b1, 1'b0, "restart2");

        // asynchronous reset mid-dwell, observed between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("async.out",   32'(out8),   32'd0);
        chk("async.ch",    32'(ch8),    32'd0);
        chk("async.valid", 32'(valid8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        step8(1'b0, 1'b1, 3'd0, 8'd2, 1'b1, 3'd0, 1'b1, 1'b0, "rscan0");
        step8(1'b0, 1'b1, 3'd0, 8'd2, 1'b1, 3'd0, 1'b1, 1'b0, "rscan1");
        step8(1'b0, 1'b1, 3'd0, 8'd2, 1'b1, 3'd0, 1'b1, 1'b0, "rscan2");
        step8(1'b0, 1'b1, 3'd0, 8'd2, 1'b1, 3'd1, 1'b1, 1'b0, "rscan3");

        step8(1'b0, 1'b0, 3'd5, 8'd0, 1'b1, 3'd5, 1'b1, 1'b0, "man5");
        for (int e = 0; e < 4; e++) begin
            step8(1'b0, 1'b1, 3'd0, 8'd0, exp3[e], 3'(e), 1'b1, 1'b0, $sformatf("dw0_%0d", e));
        end
        step8(1'b1, 1'b1, 3'd0, 8'd0, 1'b0, 3'd3, 1'b0, 1'b0, "idle8");

        // CH=5, W=4 instance; u8 stays disabled
        step5(1'b0, 1'b0, 3'd6, 8'd0, 0, 1'b0, 1'b0, "c5_s6");
        step5(1'b0, 1'b0, 3'd4, 8'd0, 4, 1'b1, 1'b0, "c5_s4");
        chk("c5_s4.nibble", 32'(out5), 32'hD);
        step5(1'b0, 1'b0, 3'd7, 8'd0, 4, 1'b0, 1'b0, "c5_s7");
        step5(1'b0, 1'b0, 3'd1, 8'd0, 1, 1'b1, 1'b0, "c5_s1");
        for (int e = 0; e < 4; e++) begin
            step5(1'b0, 1'b1, 3'd0, 8'd5, 0, 1'b1, 1'b0, $sformatf("c5_dw5_%0d", e));
        end
        step5(1'b0, 1'b1, 3'd0, 8'd1, 1, 1'b1, 1'b0, "c5_lower");
        in5 = 20'hD967B;
        step5(1'b0, 1'b1, 3'd0, 8'd1, 1, 1'b1, 1'b0, "c5_live");
        chk("c5_live.nibble", 32'(out5), 32'h7);
        for (int e = 0; e < 8; e++) begin
            step5(1'b0, 1'b1, 3'd0, 8'd1, seq5[e], 1'b1, (e == 6), $sformatf("c5_seq%0d", e));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
